// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: field widths,
// opcode/function constants, ALU operation codes and the FSM state encoding.
package mips_mc_controller_pkg;

    localparam int OPC_WIDTH  = 6;
    localparam int FUNC_WIDTH = 6;
    localparam int ST_WIDTH   = 4;

    // Opcodes (IR[31:26])
    localparam logic [OPC_WIDTH-1:0] OPC_RT   = 6'b000000;
    localparam logic [OPC_WIDTH-1:0] OPC_LW   = 6'b100011;
    localparam logic [OPC_WIDTH-1:0] OPC_SW   = 6'b101011;
    localparam logic [OPC_WIDTH-1:0] OPC_BEQ  = 6'b000100;
    localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 6'b001000;
    localparam logic [OPC_WIDTH-1:0] OPC_SLTI = 6'b001010;
    localparam logic [OPC_WIDTH-1:0] OPC_J    = 6'b000010;
    localparam logic [OPC_WIDTH-1:0] OPC_JAL  = 6'b000011;

    // Function field codes (IR[5:0]) for R-type
    localparam logic [FUNC_WIDTH-1:0] F_ADD = 6'b100000;
    localparam logic [FUNC_WIDTH-1:0] F_SUB = 6'b100010;
    localparam logic [FUNC_WIDTH-1:0] F_AND = 6'b100100;
    localparam logic [FUNC_WIDTH-1:0] F_OR  = 6'b100101;
    localparam logic [FUNC_WIDTH-1:0] F_SLT = 6'b101010;
    localparam logic [FUNC_WIDTH-1:0] F_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [ST_WIDTH-1:0] {
        IF      = 4'd0,
        ID      = 4'd1,
        EX_R    = 4'd2,
        WB_R    = 4'd3,
        EX_I    = 4'd4,
        WB_I    = 4'd5,
        MEM_ADR = 4'd6,
        MEM_RD  = 4'd7,
        WB_LW   = 4'd8,
        MEM_WR  = 4'd9,
        BR      = 4'd10,
        JMP     = 4'd11,
        JAL     = 4'd12,
        JR      = 4'd13
    } state_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bus between the multi-cycle controller and the shared datapath.
//   master (controller): takes opc/func/zero, drives every enable/select
//                        plus the debug state.
//   slave  (datapath)  : the mirror image.
interface mips_mc_controller_if;
    import mips_mc_controller_pkg::*;

    logic [OPC_WIDTH-1:0]  opc;
    logic [FUNC_WIDTH-1:0] func;
    logic                  zero;
    logic                  pc_ld;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic [1:0]            reg_dst;
    logic [1:0]            mem_to_reg;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [2:0]            alu_control;
    logic [1:0]            pc_src;
    logic [ST_WIDTH-1:0]   state;

    modport master (
        input  opc, func, zero,
        output pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
               pc_src, state
    );

    modport slave (
        output opc, func, zero,
        input  pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
               pc_src, state
    );

endinterface

// File: rtl/mips_alu_dec.sv
// R-type ALU decoder: maps the function field to the ALU operation code.
//   func        in  function field IR[5:0]
//   alu_control out ALU operation; unknown functions fall back to add
module mips_alu_dec
    import mips_mc_controller_pkg::*;
(
    input  logic [FUNC_WIDTH-1:0] func,
    output logic [2:0]            alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (func)
            F_ADD:   alu_control = ALU_ADD;
            F_SUB:   alu_control = ALU_SUB;
            F_AND:   alu_control = ALU_AND;
            F_OR:    alu_control = ALU_OR;
            F_SLT:   alu_control = ALU_SLT;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit. One FSM state per clock sequences the
// shared datapath through fetch, decode, execute, memory and write-back.
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset (returns to IF)
//   bus  master side of the controller/datapath bus: opc, func, zero in;
//        all register enables, mux selects, ALU op and debug state out
module mips_mc_controller
    import mips_mc_controller_pkg::*;
#(
    parameter int OPC_W  = 6,
    parameter int FUNC_W = 6,
    parameter int ST_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_mc_controller_if.master   bus
);

    state_t            state_q;
    state_t            state_d;
    logic [OPC_W-1:0]  opc;
    logic [FUNC_W-1:0] func;
    logic [ST_W-1:0]   state_bits;
    logic [2:0]        alu_r;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;

    assign opc  = bus.opc;
    assign func = bus.func;

    mips_alu_dec u_alu_dec (
        .func        (func),
        .alu_control (alu_r)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = IF;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_control   = ALU_AND;
        pc_src        = 2'b00;
        case (state_q)
            IF: begin
                mem_read    = 1'b1;
                ir_write    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                pc_write    = 1'b1;
                state_d     = ID;
            end
            ID: begin
                // Speculative branch target (PC+4 + imm<<2) lands in ALUOut.
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                case (opc)
                    OPC_RT:           state_d = (func == F_JR) ? JR : EX_R;
                    OPC_LW, OPC_SW:   state_d = MEM_ADR;
                    OPC_ADDI, OPC_SLTI: state_d = EX_I;
                    OPC_BEQ:          state_d = BR;
                    OPC_J:            state_d = JMP;
                    OPC_JAL:          state_d = JAL;
                    default:          state_d = IF;
                endcase
            end
            EX_R: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b00;
                alu_control = alu_r;
                state_d     = WB_R;
            end
            WB_R: begin
                reg_dst   = 2'b01;
                reg_write = 1'b1;
                state_d   = IF;
            end
            EX_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = (opc == OPC_SLTI) ? ALU_SLT : ALU_ADD;
                state_d     = WB_I;
            end
            WB_I: begin
                reg_write = 1'b1;
                state_d   = IF;
            end
            MEM_ADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                state_d     = (opc == OPC_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = WB_LW;
            end
            WB_LW: begin
                mem_to_reg = 2'b01;
                reg_write  = 1'b1;
                state_d    = IF;
            end
            MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                state_d   = IF;
            end
            BR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b00;
                alu_control   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                state_d       = IF;
            end
            JMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = IF;
            end
            JAL: begin
                // Old PC (already PC+4) is written to r31 on the same edge
                // that loads the jump target.
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                reg_write  = 1'b1;
                state_d    = IF;
            end
            JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
                state_d  = IF;
            end
            default: state_d = IF;
        endcase
    end

    // Architectural write enables are suppressed while rst is high so a reset
    // arriving mid-instruction cannot commit a register, memory or PC write.
    assign bus.pc_ld       = ~rst & (pc_write | (pc_write_cond & bus.zero));
    assign bus.mem_write   = ~rst & mem_write;
    assign bus.ir_write    = ~rst & ir_write;
    assign bus.reg_write   = ~rst & reg_write;
    assign bus.i_or_d      = i_or_d;
    assign bus.mem_read    = mem_read;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_control;
    assign bus.pc_src      = pc_src;

    assign state_bits = state_q;
    assign bus.state  = state_bits;

endmodule

// File: tb/tb_mips_mc_controller.sv
module tb_mips_mc_controller;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    mips_mc_controller_if bus ();

    mips_mc_controller #(
        .OPC_W  (6),
        .FUNC_W (6),
        .ST_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.opc = 6'd0; bus.func = 6'd0; bus.zero = 1'b0;
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", bus.state, 0); end
        vectors++; if (bus.reg_write !== 1'b0) begin miscompares++; $display("FAIL reset_reg_write: got %0b expected 0", bus.reg_write); end
        vectors++; if (bus.pc_ld !== 1'b0) begin miscompares++; $display("FAIL reset_pc_ld_held: got %0b expected 0", bus.pc_ld); end
        rst = 1'b0; #1;
        vectors++; if (bus.mem_read !== 1'b1 || bus.ir_write !== 1'b1 || bus.pc_ld !== 1'b1) begin miscompares++; $display("FAIL if_strobes: got rd=%0b irw=%0b pcld=%0b expected 1 1 1", bus.mem_read, bus.ir_write, bus.pc_ld); end
        vectors++; if (bus.alu_src_b !== 2'b01 || bus.alu_control !== 3'b010 || bus.mem_write !== 1'b0) begin miscompares++; $display("FAIL if_alu: got srcb=%b alu=%b memw=%b expected 01 010 0", bus.alu_src_b, bus.alu_control, bus.mem_write); end
    endtask

    task automatic test_rtype;
        bus.opc = 6'b000000; bus.func = 6'b100010;
        tick();
        vectors++; if (bus.state !== 4'd1 || bus.alu_src_b !== 2'b11) begin miscompares++; $display("FAIL rtype_id: got st=%0d srcb=%b expected 1 11", bus.state, bus.alu_src_b); end
        tick();
        vectors++; if (bus.state !== 4'd2 || bus.alu_control !== 3'b110 || bus.alu_src_a !== 1'b1 || bus.reg_write !== 1'b0) begin miscompares++; $display("FAIL rtype_ex: got st=%0d alu=%b srca=%b rw=%b expected 2 110 1 0", bus.state, bus.alu_control, bus.alu_src_a, bus.reg_write); end
        tick();
        vectors++; if (bus.state !== 4'd3 || bus.reg_write !== 1'b1 || bus.reg_dst !== 2'b01) begin miscompares++; $display("FAIL rtype_wb: got st=%0d rw=%b dst=%b expected 3 1 01", bus.state, bus.reg_write, bus.reg_dst); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL rtype_done: got %0d expected 0", bus.state); end
        // slt via unrelated func, then unknown func falls back to add
        bus.func = 6'b101010; tick(); tick();
        vectors++; if (bus.alu_control !== 3'b111) begin miscompares++; $display("FAIL rtype_slt: got %b expected 111", bus.alu_control); end
        tick(); tick();
        bus.func = 6'b111111; tick(); tick();
        vectors++; if (bus.alu_control !== 3'b010) begin miscompares++; $display("FAIL rtype_unknown: got %b expected 010", bus.alu_control); end
        tick(); tick();
    endtask

    task automatic test_lw;
        bus.opc = 6'b100011;
        tick(); tick();
        vectors++; if (bus.state !== 4'd6 || bus.alu_src_b !== 2'b10) begin miscompares++; $display("FAIL lw_adr: got st=%0d srcb=%b expected 6 10", bus.state, bus.alu_src_b); end
        tick();
        vectors++; if (bus.state !== 4'd7 || bus.mem_read !== 1'b1 || bus.i_or_d !== 1'b1 || bus.mem_write !== 1'b0) begin miscompares++; $display("FAIL lw_memrd: got st=%0d rd=%b iod=%b wr=%b expected 7 1 1 0", bus.state, bus.mem_read, bus.i_or_d, bus.mem_write); end
        tick();
        vectors++; if (bus.state !== 4'd8 || bus.mem_to_reg !== 2'b01 || bus.reg_write !== 1'b1 || bus.reg_dst !== 2'b00) begin miscompares++; $display("FAIL lw_wb: got st=%0d m2r=%b rw=%b dst=%b expected 8 01 1 00", bus.state, bus.mem_to_reg, bus.reg_write, bus.reg_dst); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL lw_done: got %0d expected 0", bus.state); end
    endtask

    task automatic test_sw_slti;
        bus.opc = 6'b101011;
        tick(); tick(); tick();
        vectors++; if (bus.state !== 4'd9 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.i_or_d !== 1'b1) begin miscompares++; $display("FAIL sw_memwr: got st=%0d wr=%b rd=%b iod=%b expected 9 1 0 1", bus.state, bus.mem_write, bus.mem_read, bus.i_or_d); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL sw_done: got %0d expected 0", bus.state); end
        bus.opc = 6'b001010;
        tick(); tick();
        vectors++; if (bus.state !== 4'd4 || bus.alu_control !== 3'b111 || bus.alu_src_b !== 2'b10) begin miscompares++; $display("FAIL slti_ex: got st=%0d alu=%b srcb=%b expected 4 111 10", bus.state, bus.alu_control, bus.alu_src_b); end
        tick();
        vectors++; if (bus.state !== 4'd5 || bus.reg_write !== 1'b1 || bus.reg_dst !== 2'b00) begin miscompares++; $display("FAIL slti_wb: got st=%0d rw=%b dst=%b expected 5 1 00", bus.state, bus.reg_write, bus.reg_dst); end
        tick();
    endtask

    task automatic test_beq;
        bus.opc = 6'b000100; bus.zero = 1'b1;
        tick(); tick();
        vectors++; if (bus.state !== 4'd10 || bus.pc_ld !== 1'b1 || bus.pc_src !== 2'b01 || bus.alu_control !== 3'b110) begin miscompares++; $display("FAIL beq_taken: got st=%0d pcld=%b src=%b alu=%b expected 10 1 01 110", bus.state, bus.pc_ld, bus.pc_src, bus.alu_control); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL beq_taken_done: got %0d expected 0", bus.state); end
        bus.zero = 1'b0;
        tick(); tick();
        vectors++; if (bus.state !== 4'd10 || bus.pc_ld !== 1'b0) begin miscompares++; $display("FAIL beq_not_taken: got st=%0d pcld=%b expected 10 0", bus.state, bus.pc_ld); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL beq_nt_done: got %0d expected 0", bus.state); end
    endtask

    task automatic test_jal_jr;
        bus.opc = 6'b000011;
        tick(); tick();
        vectors++; if (bus.state !== 4'd12 || bus.reg_write !== 1'b1 || bus.reg_dst !== 2'b10 || bus.mem_to_reg !== 2'b10 || bus.pc_ld !== 1'b1 || bus.pc_src !== 2'b10) begin miscompares++; $display("FAIL jal: got st=%0d rw=%b dst=%b m2r=%b pcld=%b src=%b expected 12 1 10 10 1 10", bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_ld, bus.pc_src); end
        tick();
        bus.opc = 6'b000000; bus.func = 6'b001000;
        tick(); tick();
        vectors++; if (bus.state !== 4'd13 || bus.pc_src !== 2'b11 || bus.pc_ld !== 1'b1 || bus.reg_write !== 1'b0) begin miscompares++; $display("FAIL jr: got st=%0d src=%b pcld=%b rw=%b expected 13 11 1 0", bus.state, bus.pc_src, bus.pc_ld, bus.reg_write); end
        tick();
        bus.opc = 6'b000010;
        tick(); tick();
        vectors++; if (bus.state !== 4'd11 || bus.pc_src !== 2'b10 || bus.pc_ld !== 1'b1) begin miscompares++; $display("FAIL j: got st=%0d src=%b pcld=%b expected 11 10 1", bus.state, bus.pc_src, bus.pc_ld); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL j_done: got %0d expected 0", bus.state); end
    endtask

    task automatic test_nop;
        bus.opc = 6'b111111; bus.zero = 1'b1;
        tick();
        vectors++; if (bus.state !== 4'd1 || bus.reg_write !== 1'b0 || bus.mem_write !== 1'b0 || bus.pc_ld !== 1'b0) begin miscompares++; $display("FAIL nop_id: got st=%0d rw=%b wr=%b pcld=%b expected 1 0 0 0", bus.state, bus.reg_write, bus.mem_write, bus.pc_ld); end
        tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL nop_done: got %0d expected 0", bus.state); end
        bus.zero = 1'b0;
    endtask

    task automatic test_reset_mid_lw;
        bus.opc = 6'b100011;
        tick(); tick(); tick(); tick();
        vectors++; if (bus.state !== 4'd8) begin miscompares++; $display("FAIL rst_lw_reach: got %0d expected 8", bus.state); end
        rst = 1'b1; #1;
        vectors++; if (bus.reg_write !== 1'b0) begin miscompares++; $display("FAIL rst_lw_no_write: got %b expected 0", bus.reg_write); end
        tick();
        vectors++; if (bus.state !== 4'd0 || bus.reg_write !== 1'b0) begin miscompares++; $display("FAIL rst_lw_cycle1: got st=%0d rw=%b expected 0 0", bus.state, bus.reg_write); end
        tick();
        vectors++; if (bus.state !== 4'd0 || bus.reg_write !== 1'b0) begin miscompares++; $display("FAIL rst_lw_cycle2: got st=%0d rw=%b expected 0 0", bus.state, bus.reg_write); end
        rst = 1'b0; #1;
        vectors++; if (bus.state !== 4'd0 || bus.pc_ld !== 1'b1) begin miscompares++; $display("FAIL rst_lw_release: got st=%0d pcld=%b expected 0 1", bus.state, bus.pc_ld); end
        tick();
        vectors++; if (bus.state !== 4'd1) begin miscompares++; $display("FAIL rst_lw_resume: got %0d expected 1", bus.state); end
        tick(); tick(); tick(); tick();
        vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL rst_lw_finish: got %0d expected 0", bus.state); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_rtype();
        test_lw();
        test_sw_slti();
        test_beq();
        test_jal_jr();
        test_nop();
        test_reset_mid_lw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
